// File: rtl/fpmul_scheduler_if.sv
// Request/result bundle for fpmul_scheduler.
// Two requesters each present valid, operand A, operand B and an output mode.
// The scheduler returns a combinational ready per requester and one result
// channel (valid, id, res, sat) with no backpressure.
//   slave  : the scheduler side
//   master : the requester / result-consumer side
interface fpmul_scheduler_if #(
    parameter int NB_A  = 16,
    parameter int NB_B  = 12,
    parameter int NB_FR = 28
) ();
    logic             i_req0_valid;
    logic             i_req1_valid;
    logic             o_req0_ready;
    logic             o_req1_ready;
    logic [NB_A-1:0]  i_req0_a;
    logic [NB_A-1:0]  i_req1_a;
    logic [NB_B-1:0]  i_req0_b;
    logic [NB_B-1:0]  i_req1_b;
    logic [1:0]       i_req0_mode;
    logic [1:0]       i_req1_mode;
    logic             o_valid;
    logic             o_id;
    logic [NB_FR-1:0] o_res;
    logic             o_sat;

    modport slave (
        input  i_req0_valid, i_req1_valid,
        input  i_req0_a, i_req1_a, i_req0_b, i_req1_b,
        input  i_req0_mode, i_req1_mode,
        output o_req0_ready, o_req1_ready,
        output o_valid, o_id, o_res, o_sat
    );

    modport master (
        output i_req0_valid, i_req1_valid,
        output i_req0_a, i_req1_a, i_req0_b, i_req1_b,
        output i_req0_mode, i_req1_mode,
        input  o_req0_ready, o_req1_ready,
        input  o_valid, o_id, o_res, o_sat
    );
endinterface

// File: rtl/fpmul_scheduler.sv
// Two-requester round-robin scheduler in front of a 2-stage signed
// fixed-point multiplier, S(16,14) x S(12,11) -> S(28,25).
// Ports:
//   clk      single clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      fpmul_scheduler_if.slave: per-requester valid/ready/a/b/mode,
//            result channel o_valid/o_id/o_res/o_sat
// Output modes: 00 full product, 01 S(11,10) truncate+wrap,
//               10 S(11,10) truncate+saturate, 11 S(9,8) round half-up+saturate.
// Latency from handshake to o_valid is 2 cycles, throughput one op per cycle.
module fpmul_scheduler #(
    parameter int NB_A  = 16,
    parameter int NB_B  = 12,
    parameter int NB_FR = 28
) (
    input  logic               clk,
    input  logic               i_rst_n,
    fpmul_scheduler_if.slave   bus
);
    // Narrow formats: 11-bit S(11,10) and 9-bit S(9,8) taken from S(28,25).
    localparam int NB_T  = 11;
    localparam int NB_R  = 9;
    localparam int SH_T  = 15;
    localparam int SH_R  = 17;
    localparam int NB_TW = NB_FR - SH_T;       // width after truncation shift
    localparam int NB_RW = NB_FR + 1 - SH_R;   // width after rounding shift
    localparam logic [NB_FR:0] RND_HALF = (NB_FR+1)'(1) << (SH_R - 1);

    logic               r_ptr;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_hs;
    logic [NB_A-1:0]    w_a;
    logic [NB_B-1:0]    w_b;
    logic [1:0]         w_mode;
    logic [NB_FR-1:0]   w_a_ext;
    logic [NB_FR-1:0]   w_b_ext;
    logic [NB_FR-1:0]   w_prod;

    logic               r_s1_valid;
    logic [NB_FR-1:0]   r_s1_prod;
    logic [1:0]         r_s1_mode;
    logic               r_s1_id;

    logic [NB_TW-1:0]   w_trunc;
    logic [NB_FR:0]     w_rsum;
    logic [NB_RW-1:0]   w_rnd;
    logic               w_trunc_ovf;
    logic               w_rnd_ovf;
    logic [NB_T-1:0]    w_trunc_sat;
    logic [NB_R-1:0]    w_rnd_sat;
    logic [NB_FR-1:0]   w_fmt_res;
    logic               w_fmt_sat;

    logic               r_valid;
    logic               r_id;
    logic [NB_FR-1:0]   r_res;
    logic               r_sat;

    // Favoured requester wins; the other only when the favoured one is idle.
    // Readys are forced low while reset is held.
    assign w_gnt0 = i_rst_n & bus.i_req0_valid & (~r_ptr | ~bus.i_req1_valid);
    assign w_gnt1 = i_rst_n & bus.i_req1_valid & ( r_ptr | ~bus.i_req0_valid);
    assign w_hs   = w_gnt0 | w_gnt1;

    assign bus.o_req0_ready = w_gnt0;
    assign bus.o_req1_ready = w_gnt1;

    assign w_a    = w_gnt1 ? bus.i_req1_a    : bus.i_req0_a;
    assign w_b    = w_gnt1 ? bus.i_req1_b    : bus.i_req0_b;
    assign w_mode = w_gnt1 ? bus.i_req1_mode : bus.i_req0_mode;

    // Both operands sign-extended to the product width so the product is exact.
    assign w_a_ext = {{(NB_FR-NB_A){w_a[NB_A-1]}}, w_a};
    assign w_b_ext = {{(NB_FR-NB_B){w_b[NB_B-1]}}, w_b};
    assign w_prod  = w_a_ext * w_b_ext;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= 1'b0;
        end else if (w_hs) begin
            r_ptr <= w_gnt0;   // favour whoever was not just served
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_prod  <= '0;
            r_s1_mode  <= 2'b00;
            r_s1_id    <= 1'b0;
        end else begin
            r_s1_valid <= w_hs;
            if (w_hs) begin
                r_s1_prod <= w_prod;
                r_s1_mode <= w_mode;
                r_s1_id   <= w_gnt1;
            end
        end
    end

    // Arithmetic shift of the signed product is a plain bit-slice (floor).
    assign w_trunc = r_s1_prod[NB_FR-1:SH_T];
    assign w_rsum  = {r_s1_prod[NB_FR-1], r_s1_prod} + RND_HALF;
    assign w_rnd   = w_rsum[NB_FR:SH_R];

    // Fits the narrow range when all bits above its sign bit match the sign.
    assign w_trunc_ovf = ~((&w_trunc[NB_TW-1:NB_T-1]) | ~(|w_trunc[NB_TW-1:NB_T-1]));
    assign w_rnd_ovf   = ~((&w_rnd[NB_RW-1:NB_R-1])   | ~(|w_rnd[NB_RW-1:NB_R-1]));

    assign w_trunc_sat = w_trunc[NB_TW-1] ? {1'b1, {(NB_T-1){1'b0}}} : {1'b0, {(NB_T-1){1'b1}}};
    assign w_rnd_sat   = w_rnd[NB_RW-1]   ? {1'b1, {(NB_R-1){1'b0}}} : {1'b0, {(NB_R-1){1'b1}}};

    always_comb begin
        w_fmt_res = '0;
        w_fmt_sat = 1'b0;
        case (r_s1_mode)
            2'b00: begin
                w_fmt_res = r_s1_prod;
            end
            2'b01: begin
                w_fmt_res = {{(NB_FR-NB_T){w_trunc[NB_T-1]}}, w_trunc[NB_T-1:0]};
            end
            2'b10: begin
                if (w_trunc_ovf) begin
                    w_fmt_res = {{(NB_FR-NB_T){w_trunc_sat[NB_T-1]}}, w_trunc_sat};
                    w_fmt_sat = 1'b1;
                end else begin
                    w_fmt_res = {{(NB_FR-NB_T){w_trunc[NB_T-1]}}, w_trunc[NB_T-1:0]};
                end
            end
            default: begin
                if (w_rnd_ovf) begin
                    w_fmt_res = {{(NB_FR-NB_R){w_rnd_sat[NB_R-1]}}, w_rnd_sat};
                    w_fmt_sat = 1'b1;
                end else begin
                    w_fmt_res = {{(NB_FR-NB_R){w_rnd[NB_R-1]}}, w_rnd[NB_R-1:0]};
                end
            end
        endcase
    end

    // Result registers only load on a live op, so they hold between strobes.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_id    <= 1'b0;
            r_res   <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_id  <= r_s1_id;
                r_res <= w_fmt_res;
                r_sat <= w_fmt_sat;
            end
        end
    end

    assign bus.o_valid = r_valid;
    assign bus.o_id    = r_id;
    assign bus.o_res   = r_res;
    assign bus.o_sat   = r_sat;
endmodule

// File: tb/tb_fpmul_scheduler.sv
// Bench for fpmul_scheduler: drives both requesters, predicts grants with its
// own round-robin pointer, queues expected results at handshake time and
// compares them (value, id, arrival cycle) when o_valid strobes.
module tb_fpmul_scheduler;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    logic tb_ptr;

    typedef struct {
        logic        id;
        logic [27:0] res;
        logic        sat;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    logic        last_id;
    logic [27:0] last_res;
    logic        last_sat;

    fpmul_scheduler_if #(.NB_A(16), .NB_B(12), .NB_FR(28)) ifc ();

    fpmul_scheduler #(.NB_A(16), .NB_B(12), .NB_FR(28)) dut (
        .clk     (clk),
        .i_rst_n (rst_n),
        .bus     (ifc.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference arithmetic on 64-bit integers.
    function automatic void model(input logic [15:0] a, input logic [11:0] b,
                                  input logic [1:0] m,
                                  output logic [27:0] r, output logic s);
        longint p;
        longint f;
        p = longint'($signed(a)) * longint'($signed(b));
        s = 1'b0;
        case (m)
            2'd0: f = p;
            2'd1: begin
                f = (p >>> 15) & 64'h7FF;
                if (f >= 1024) f = f - 2048;
            end
            2'd2: begin
                f = p >>> 15;
                if (f > 1023) begin f = 1023; s = 1'b1; end
                else if (f < -1024) begin f = -1024; s = 1'b1; end
            end
            default: begin
                f = (p + 65536) >>> 17;
                if (f > 255) begin f = 255; s = 1'b1; end
                else if (f < -256) begin f = -256; s = 1'b1; end
            end
        endcase
        r = f[27:0];
    endfunction

    // Result monitor: reset values, scoreboard order/latency, and hold behaviour.
    always @(negedge clk) begin
        if (!rst_n) begin
            checks++;
            if (ifc.o_valid !== 1'b0 || ifc.o_id !== 1'b0 || ifc.o_res !== 28'h0 ||
                ifc.o_sat !== 1'b0 || ifc.o_req0_ready !== 1'b0 || ifc.o_req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: got valid=%b id=%b res=%h sat=%b rdy=%b%b, required all zero",
                         ifc.o_valid, ifc.o_id, ifc.o_res, ifc.o_sat, ifc.o_req0_ready, ifc.o_req1_ready);
            end
            last_id  = 1'b0;
            last_res = 28'h0;
            last_sat = 1'b0;
        end else if (ifc.o_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got id=%b res=%h at cycle %0d, required no result",
                         ifc.o_id, ifc.o_res, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (ifc.o_id !== e.id || ifc.o_res !== e.res || ifc.o_sat !== e.sat || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL result: got id=%b res=%h sat=%b cyc=%0d, required id=%b res=%h sat=%b cyc=%0d",
                             ifc.o_id, ifc.o_res, ifc.o_sat, cyc, e.id, e.res, e.sat, e.cyc);
                end
            end
            last_id  = ifc.o_id;
            last_res = ifc.o_res;
            last_sat = ifc.o_sat;
        end else begin
            checks++;
            if (ifc.o_id !== last_id || ifc.o_res !== last_res || ifc.o_sat !== last_sat) begin
                errors++;
                $display("FAIL hold: got id=%b res=%h sat=%b, required id=%b res=%h sat=%b",
                         ifc.o_id, ifc.o_res, ifc.o_sat, last_id, last_res, last_sat);
            end
        end
    end

    // One cycle of stimulus: checks readys against the bench's own arbiter and
    // queues the expected result for whichever requester is granted.
    task automatic drive(input logic v0, input logic [15:0] a0, input logic [11:0] b0, input logic [1:0] m0,
                         input logic v1, input logic [15:0] a1, input logic [11:0] b1, input logic [1:0] m1,
                         input bit use_model, input logic [27:0] xres, input logic xsat);
        logic g0;
        logic g1;
        exp_t e;
        @(negedge clk);
        #2;
        ifc.i_req0_valid = v0; ifc.i_req0_a = a0; ifc.i_req0_b = b0; ifc.i_req0_mode = m0;
        ifc.i_req1_valid = v1; ifc.i_req1_a = a1; ifc.i_req1_b = b1; ifc.i_req1_mode = m1;
        #1;
        g0 = rst_n & v0 & (~tb_ptr | ~v1);
        g1 = rst_n & v1 & ( tb_ptr | ~v0);
        checks++;
        if (ifc.o_req0_ready !== g0 || ifc.o_req1_ready !== g1) begin
            errors++;
            $display("FAIL ready: got %b%b, required %b%b (valids %b%b)",
                     ifc.o_req0_ready, ifc.o_req1_ready, g0, g1, v0, v1);
        end
        if (g0 | g1) begin
            e.id = g1;
            if (use_model) begin
                if (g1) model(a1, b1, m1, e.res, e.sat);
                else    model(a0, b0, m0, e.res, e.sat);
            end else begin
                e.res = xres;
                e.sat = xsat;
            end
            e.cyc = cyc + 2;
            sb.push_back(e);
            tb_ptr = g0;
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 28'h0, 1'b0);
    endtask

    task automatic send(input logic req, input logic [15:0] a, input logic [11:0] b,
                        input logic [1:0] m, input logic [27:0] xres, input logic xsat);
        if (req) drive(0, 0, 0, 0, 1, a, b, m, 1'b0, xres, xsat);
        else     drive(1, a, b, m, 0, 0, 0, 0, 1'b0, xres, xsat);
    endtask

    task automatic assert_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        tb_ptr = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2;
        ifc.i_req0_valid = 1'b1;
        ifc.i_req1_valid = 1'b1;
        #1;
        checks++;
        if (ifc.o_req0_ready !== 1'b0 || ifc.o_req1_ready !== 1'b0 || ifc.o_valid !== 1'b0 ||
            ifc.o_res !== 28'h0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b%b valid=%b res=%h, required 00 0 0",
                     ifc.o_req0_ready, ifc.o_req1_ready, ifc.o_valid, ifc.o_res);
        end
        ifc.i_req0_valid = 1'b0;
        ifc.i_req1_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_modes();
        send(0, 16'h4000, 12'h400, 2'b10, 28'h0000200, 1'b0);
        send(0, 16'h4000, 12'h400, 2'b00, 28'h1000000, 1'b0);
        send(1, 16'h7FFF, 12'h7FF, 2'b10, 28'h00003FF, 1'b1);
        send(1, 16'h7FFF, 12'h7FF, 2'b01, 28'hFFFFFFE, 1'b0);
        send(0, 16'h4000, 12'h004, 2'b11, 28'h0000001, 1'b0);
        send(0, 16'hC000, 12'h004, 2'b11, 28'h0000000, 1'b0);
        send(1, 16'h8000, 12'h7FF, 2'b10, 28'hFFFFC00, 1'b1);
        send(1, 16'h8000, 12'h7FF, 2'b01, 28'h0000001, 1'b0);
        send(0, 16'h7FFF, 12'h7FF, 2'b11, 28'h00000FF, 1'b1);
        send(0, 16'h8000, 12'h7FF, 2'b11, 28'hFFFFF00, 1'b1);
        send(1, 16'h8000, 12'h800, 2'b00, 28'h4000000, 1'b0);
        idle(4);
    endtask

    task automatic test_hold();
        send(0, 16'h2000, 12'h300, 2'b00, 28'h0600000, 1'b0);
        idle(6);
    endtask

    task automatic test_back_to_back();
        assert_reset();
        ifc.i_req0_valid = 1'b1;
        ifc.i_req1_valid = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++)
            drive(1, 16'($urandom), 12'($urandom), 2'($urandom), 1, 16'($urandom), 12'($urandom), 2'($urandom),
                  1'b1, 28'h0, 1'b0);
        idle(4);
    endtask

    function automatic logic [15:0] pick_a();
        case ($urandom_range(0, 4))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'h4000;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [11:0] pick_b();
        case ($urandom_range(0, 4))
            0: return 12'h7FF;
            1: return 12'h800;
            2: return 12'h004;
            default: return 12'($urandom);
        endcase
    endfunction

    task automatic test_random();
        for (int i = 0; i < 150; i++)
            drive(1'($urandom_range(0, 9) < 7), pick_a(), pick_b(), 2'($urandom),
                  1'($urandom_range(0, 9) < 6), pick_a(), pick_b(), 2'($urandom),
                  1'b1, 28'h0, 1'b0);
        idle(4);
    endtask

    task automatic test_reset_midop();
        int pulses;
        send(0, 16'h4000, 12'h400, 2'b00, 28'h1000000, 1'b0);
        idle(2);
        send(1, 16'h7FFF, 12'h7FF, 2'b10, 28'h00003FF, 1'b1);
        assert_reset();
        #1;
        checks++;
        if (ifc.o_valid !== 1'b0 || ifc.o_res !== 28'h0 || ifc.o_id !== 1'b0 || ifc.o_sat !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset_clear: got valid=%b res=%h id=%b sat=%b, required all zero",
                     ifc.o_valid, ifc.o_res, ifc.o_id, ifc.o_sat);
        end
        ifc.i_req0_valid = 1'b0;
        ifc.i_req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (ifc.o_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL midop_discard: got %0d result pulses after reset, required 0", pulses);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d results outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        tb_ptr = 1'b0;
        rst_n  = 1'b0;
        ifc.i_req0_valid = 1'b0; ifc.i_req0_a = '0; ifc.i_req0_b = '0; ifc.i_req0_mode = 2'b00;
        ifc.i_req1_valid = 1'b0; ifc.i_req1_a = '0; ifc.i_req1_b = '0; ifc.i_req1_mode = 2'b00;
        repeat (3) @(posedge clk);
        test_reset();
        test_modes();
        test_hold();
        test_back_to_back();
        test_random();
        test_reset_midop();
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpmul_scheduler.md
FPMUL_SCHEDULER -- requirements
Module: fpmul_scheduler

Interface
REQ-001 Parameter NB_A, default 16, multiplicand A width, S(16,14).
REQ-002 Parameter NB_B, default 12, multiplier B width, S(12,11).
REQ-003 Parameter NB_FR, default 28, full product width, S(28,25).
REQ-004 Port clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port i_rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port i_req0_valid / i_req1_valid  in  1 each  requester 0/1 has an operation pending.
REQ-007 Port o_req0_ready / o_req1_ready  out  1 each  grant; the handshake completes on a cycle where valid and ready are both high.
REQ-008 Port i_req0_a / i_req1_a  in  NB_A each  operand A, two's complement.
REQ-009 Port i_req0_b / i_req1_b  in  NB_B each  operand B, two's complement.
REQ-010 Port i_req0_mode / i_req1_mode  in  2 each  output format: 00 full, 01 trunc-wrap S(11,10), 10 trunc-sat S(11,10), 11 round-sat S(9,8).
REQ-011 Port o_valid  out  1  result strobe, one cycle per accepted operation.
REQ-012 Port o_id  out  1  requester index of the current result.
REQ-013 Port o_res  out  NB_FR  formatted result, sign-extended to NB_FR.
REQ-014 Port o_sat  out  1  high when a saturating mode clipped the current result.

Function
REQ-015 At most one ready SHALL be high per cycle; ready SHALL be asserted only toward a requester whose valid is high.
REQ-016 Arbitration SHALL be round-robin: a 1-bit priority pointer selects the favoured requester, and the other requester is granted only when the favoured one is idle.
REQ-017 After each completed handshake, the pointer SHALL move to the non-granted requester; with no handshake it SHALL hold.
REQ-018 Ready SHALL be combinational from the valids and the pointer; there is no backpressure on the output, so a grant is possible every cycle.
REQ-019 Stage 1 SHALL register the signed product A*B (NB_FR bits, exact), the mode and the id, together with a stage-1 valid bit.
REQ-020 Stage 2 SHALL register the formatted result, the sat flag, the id and o_valid; latency is exactly 2 cycles from the handshake to o_valid.
REQ-021 Mode 00: o_res SHALL equal the full product.
REQ-022 Mode 01: drop 15 LSBs (floor), keep the low 11 bits, sign-extend; o_sat=0.
REQ-023 Mode 10: drop 15 LSBs (floor); if the 13-bit value exceeds the 11-bit range, clip to 0x3FF or 0x400 and set o_sat=1.
REQ-024 Mode 11: add 2^16, drop 17 LSBs (round half-up); if the value exceeds the 9-bit range, clip to 0x0FF or 0x100 and set o_sat=1.
REQ-025 When o_valid=0, o_res, o_id and o_sat SHALL hold their last values.
REQ-026 The pipeline SHALL accept a new operation every cycle (throughput 1/cycle); back-to-back results SHALL appear in grant order.

Reset
REQ-027 While i_rst_n=0: pointer=0 (req0 favoured), stage valids=0, o_valid=0, o_id=0, o_res=0, o_sat=0; readys low.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight operations; no o_valid pulse for them after release.
REQ-029 The first grant SHALL be possible on the first rising edge after i_rst_n deasserts.

Verification
REQ-030 req0 only, A=0x4000, B=0x400, mode 10 -> after 2 cycles: o_valid=1, o_id=0, o_res=0x200, o_sat=0; the same operands in mode 00 -> o_res=0x1000000.
REQ-031 A=0x7FFF, B=0x7FF: mode 10 -> o_res=0x3FF, o_sat=1; mode 01 -> low 11 bits 0x7FE (sign-extended), o_sat=0.
REQ-032 Mode 11 with A=0x4000, B=0x004 -> o_res=0x001; with A=0xC000, B=0x004 -> o_res=0x000 (round half-up).
REQ-033 Both valids held high from reset release -> grants alternate req0, req1, req0, ...; o_id sequence 0,1,0,... on consecutive cycles starting 2 cycles after the first grant.
REQ-034 Handshake at cycle N, i_rst_n pulsed low at cycle N+1 -> no o_valid ever for that operation; all outputs 0 during reset.
